// File: rtl/frame_rx_checker.sv
// frame_rx_checker
//
// Receives frames from an 8-bit byte pipe, one frame per rx_dv burst.
// Each frame is: one or more 0x55 preamble bytes, a 0xD5 SFD, N>=1 payload
// bytes, and one checksum byte equal to the 8-bit sum of the payload.
// Preamble and SFD are stripped and payload bytes are buffered in a FIFO.
// The FIFO is drained over a valid/ready stream. That stream marks the final
// byte of each frame and flags frames whose checksum failed.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   rxd, rx_dv   incoming byte and burst qualifier
//   out_data     FIFO head payload byte (0 when empty)
//   out_last     head is the final byte of its frame
//   out_err      head belongs to a bad frame (meaningful with out_last)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts the head when out_valid is also high
//   frame_done   one-cycle pulse after every burst
//   err_code     with frame_done: 0 ok, 1 checksum, 2 format, 3 overflow
//   frame_cnt    count of code-0 frames (wraps)
//   err_cnt      count of non-zero-code frames (wraps)
module frame_rx_checker #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAYLOAD, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  h1_reg, h1_next;       // older held byte
  logic [7:0]  h0_reg, h0_next;       // newer held byte
  logic [1:0]  hcnt_reg, hcnt_next;
  logic [7:0]  sum_reg, sum_next;
  logic [1:0]  drop_code_reg, drop_code_next;
  logic        pushed_reg, pushed_next;   // current frame has written >=1 byte
  logic        marker_reg, marker_next;   // error marker still owed to the FIFO
  logic        skip_reg;                  // burst straddled reset: ignore its tail
  logic        fd_reg, fd_next;
  logic [1:0]  code_reg, code_next;
  logic [15:0] frame_cnt_reg, err_cnt_reg;

  // FIFO entry layout: {last, err, data}
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic       full, empty, pop;
  logic       dpush, dpush_last, dpush_err;
  logic       marker_push, push_fire;
  logic [9:0] wr_word, head;
  logic [7:0] sum_plus;

  assign full        = (count_reg == FULL_COUNT);
  assign empty       = (count_reg == '0);
  assign pop         = !empty && out_ready;
  assign marker_push = marker_reg && !full;
  // A data push and a pending marker never coincide: the marker is only owed
  // after the frame that pushed data has already left PAYLOAD, and new frames
  // are refused while it is owed.
  assign push_fire   = (dpush && !full) || marker_push;
  assign wr_word     = dpush ? {dpush_last, dpush_err, h1_reg} : {1'b1, 1'b1, 8'h00};
  assign sum_plus    = sum_reg + h1_reg;

  always_comb begin
    state_next     = state_reg;
    h1_next        = h1_reg;
    h0_next        = h0_reg;
    hcnt_next      = hcnt_reg;
    sum_next       = sum_reg;
    drop_code_next = drop_code_reg;
    pushed_next    = pushed_reg;
    marker_next    = marker_reg && !marker_push;
    fd_next        = 1'b0;
    code_next      = code_reg;
    dpush          = 1'b0;
    dpush_last     = 1'b0;
    dpush_err      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rx_dv && !skip_reg) begin
          if (marker_reg) begin
            state_next     = S_DROP;
            drop_code_next = 2'd3;
          end else if (rxd == 8'h55) begin
            state_next = S_PRE;
          end else begin
            state_next     = S_DROP;
            drop_code_next = 2'd2;
          end
        end
      end

      S_PRE: begin
        if (!rx_dv) begin
          fd_next    = 1'b1;
          code_next  = 2'd2;
          state_next = S_IDLE;
        end else if (rxd == 8'hD5) begin
          state_next = S_PAYLOAD;
        end else if (rxd != 8'h55) begin
          state_next     = S_DROP;
          drop_code_next = 2'd2;
        end
      end

      S_PAYLOAD: begin
        if (rx_dv) begin
          // Two bytes are held back so the trailing checksum is never pushed.
          if (hcnt_reg == 2'd2) begin
            dpush = 1'b1;
            if (full) begin
              state_next     = S_DROP;
              drop_code_next = 2'd3;
              marker_next    = pushed_reg;
            end else begin
              sum_next    = sum_plus;
              pushed_next = 1'b1;
            end
          end else begin
            hcnt_next = hcnt_reg + 2'd1;
          end
          h1_next = h0_reg;
          h0_next = rxd;
        end else begin
          fd_next    = 1'b1;
          state_next = S_IDLE;
          if (hcnt_reg == 2'd2) begin
            // h1 is the final payload byte, h0 the received checksum.
            dpush      = 1'b1;
            dpush_last = 1'b1;
            dpush_err  = (sum_plus != h0_reg);
            if (full) begin
              code_next   = 2'd3;
              marker_next = pushed_reg;
            end else begin
              code_next = dpush_err ? 2'd1 : 2'd0;
            end
          end else begin
            code_next = 2'd2;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) begin
          fd_next    = 1'b1;
          code_next  = drop_code_reg;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase

    if (state_next == S_IDLE) begin
      h1_next     = 8'h00;
      h0_next     = 8'h00;
      hcnt_next   = 2'd0;
      sum_next    = 8'h00;
      pushed_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      h1_reg        <= 8'h00;
      h0_reg        <= 8'h00;
      hcnt_reg      <= 2'd0;
      sum_reg       <= 8'h00;
      drop_code_reg <= 2'd0;
      pushed_reg    <= 1'b0;
      marker_reg    <= 1'b0;
      // A burst still active across reset is a lost partial frame; its tail
      // must not be parsed as a new (malformed) frame.
      skip_reg      <= rx_dv;
      fd_reg        <= 1'b0;
      code_reg      <= 2'd0;
      frame_cnt_reg <= 16'd0;
      err_cnt_reg   <= 16'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      h1_reg        <= h1_next;
      h0_reg        <= h0_next;
      hcnt_reg      <= hcnt_next;
      sum_reg       <= sum_next;
      drop_code_reg <= drop_code_next;
      pushed_reg    <= pushed_next;
      marker_reg    <= marker_next;
      if (!rx_dv) begin
        skip_reg <= 1'b0;
      end
      fd_reg   <= fd_next;
      code_reg <= code_next;
      if (fd_next) begin
        if (code_next == 2'd0) begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end else begin
          err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end
      if (push_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_fire && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push_fire) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_fire) begin
      mem[wr_ptr_reg] <= wr_word;
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign out_valid  = !empty;
  assign out_data   = empty ? 8'h00 : head[7:0];
  assign out_err    = !empty && head[8];
  assign out_last   = !empty && head[9];
  assign frame_done = fd_reg;
  assign err_code   = code_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_frame_rx_checker.sv
// Testbench for frame_rx_checker: table-driven frames, directed overflow and
// reset sequences, and randomized frames checked against a parsing model.
module tb_frame_rx_checker;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_done;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  frame_rx_checker #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv),
    .out_data(out_data), .out_last(out_last), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  typedef logic [7:0] bq_t[$];
  typedef logic [9:0] eq_t[$];   // {last, err, data}
  typedef logic [1:0] cq_t[$];

  typedef struct packed {
    logic [4:0]        len;
    logic [0:23][7:0]  b;
    logic [1:0]        code;
    logic [4:0]        n;     // payload bytes expected on the output
    logic              err;   // err flag expected on the final byte
  } vec_t;

  eq_t got_q;
  cq_t got_codes;
  int  q_base = 0;
  int  c_base = 0;
  int  checks = 0;
  int  failures = 0;
  int  rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int  fc_m = 0;
  int  ec_m = 0;

  // Consumer handshake driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 1);
    end
  end

  // Monitor: records every accepted entry and every frame_done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) got_codes.push_back(err_code);
      if (out_valid && out_ready) got_q.push_back({out_last, out_err, out_data});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input bq_t b, input int gap);
    foreach (b[i]) begin
      step();
      rxd   = b[i];
      rx_dv = 1'b1;
    end
    step();
    rx_dv = 1'b0;
    rxd   = 8'h00;
    repeat (gap - 1) step();
  endtask

  // Reference: parse a burst from the frame rules and list what must come out
  function automatic void ref_frame(input bq_t q, output logic [1:0] code, output eq_t exp);
    int i = 0;
    logic [7:0] s = 8'h00;
    logic [9:0] t;
    exp  = {};
    code = 2'd2;
    if (q.size() == 0 || q[0] != 8'h55) return;
    while (i < q.size() && q[i] == 8'h55) i++;
    if (i >= q.size() || q[i] != 8'hD5) return;
    i++;
    if (q.size() - i < 2) return;
    for (int k = i; k < q.size() - 1; k++) begin
      s = s + q[k];
      exp.push_back({2'b00, q[k]});
    end
    code = (s == q[q.size() - 1]) ? 2'd0 : 2'd1;
    t = exp[exp.size() - 1];
    exp[exp.size() - 1] = {1'b1, (code == 2'd1), t[7:0]};
  endfunction

  task automatic check_results(input eq_t exp_q, input cq_t exp_c, input string tag);
    int cyc = 0;
    int nq, nc;
    logic [9:0] g, x;
    while (((got_q.size() - q_base) < exp_q.size() ||
            (got_codes.size() - c_base) < exp_c.size()) && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (8) @(posedge clk);
    #1;
    nq = got_q.size() - q_base;
    nc = got_codes.size() - c_base;
    chk({tag, " entries"}, nq, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < nq; k++) begin
      g = got_q[q_base + k];
      x = exp_q[k];
      checks++;
      if (g[9] != x[9] || g[7:0] != x[7:0] || (x[9] && g[8] != x[8])) begin
        failures++;
        $display("FAIL %s entry %0d: got %h expected %h", tag, k, g, x);
      end
    end
    chk({tag, " pulses"}, nc, exp_c.size());
    for (int k = 0; k < exp_c.size() && k < nc; k++) begin
      chk({tag, " err_code"}, got_codes[c_base + k], exp_c[k]);
    end
    foreach (exp_c[k]) begin
      if (exp_c[k] == 2'd0) fc_m++;
      else                  ec_m++;
    end
    chk({tag, " frame_cnt"}, frame_cnt, fc_m);
    chk({tag, " err_cnt"}, err_cnt, ec_m);
    q_base = got_q.size();
    c_base = got_codes.size();
    $display("%s: %0d entries, %0d frame_done pulses", tag, nq, nc);
  endtask

  function automatic vec_t mk_vec(input bq_t q, input logic [1:0] code, input int n, input logic err);
    vec_t v;
    v      = '0;
    v.len  = 5'(q.size());
    for (int i = 0; i < q.size(); i++) v.b[i] = q[i];
    v.code = code;
    v.n    = 5'(n);
    v.err  = err;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    bq_t  b, b2;
    eq_t  e, e2;
    cq_t  c;
    logic [1:0] code, code2;
    logic [9:0] t;

    vecs[0] = mk_vec('{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h06}, 2'd0, 3, 1'b0);
    vecs[1] = mk_vec('{8'h55, 8'hD5, 8'h10, 8'h20, 8'h31}, 2'd1, 2, 1'b1);
    vecs[2] = mk_vec('{8'h55, 8'hAA, 8'h55, 8'hD5, 8'h01, 8'h01}, 2'd2, 0, 1'b0);
    vecs[3] = mk_vec('{8'h55, 8'hD5, 8'h07}, 2'd2, 0, 1'b0);
    vecs[4] = mk_vec('{8'h55, 8'hD5, 8'hFF, 8'h01, 8'h00}, 2'd0, 2, 1'b0);
    vecs[5] = mk_vec('{8'hD5, 8'h01, 8'h01}, 2'd2, 0, 1'b0);
    vecs[6] = mk_vec('{8'h55, 8'h55, 8'h55}, 2'd2, 0, 1'b0);
    vecs[7] = mk_vec('{8'h55, 8'hD5}, 2'd2, 0, 1'b0);
    vecs[8] = mk_vec('{8'h55, 8'hD5, 8'h80, 8'h80}, 2'd0, 1, 1'b0);
    vecs[9] = mk_vec('{8'h55, 8'hD5, 8'h42, 8'h43}, 2'd1, 1, 1'b1);

    // Reset state
    repeat (3) step();
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_err", out_err, 0);
    chk("rst out_data", out_data, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst err_code", err_code, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    step();

    // Table-driven frames, consumer always ready
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      b = {};
      e = {};
      for (int k = 0; k < vecs[i].len; k++) b.push_back(vecs[i].b[k]);
      for (int k = 0; k < vecs[i].n; k++) begin
        t = {2'b00, vecs[i].b[vecs[i].len - 1 - vecs[i].n + k]};
        if (k == vecs[i].n - 1) t[9:8] = {1'b1, vecs[i].err};
        e.push_back(t);
      end
      c = '{vecs[i].code};
      send_burst(b, 2);
      check_results(e, c, $sformatf("vec%0d", i));
    end

    // Overflow: 20-byte payload into a stalled FIFO, then a frame while the
    // marker is still owed
    rdy_mode = 0;
    step();
    step();
    b = '{8'h55, 8'hD5};
    for (int k = 1; k <= 20; k++) b.push_back(8'(k));
    b.push_back(8'hD2);
    b2 = '{8'h55, 8'hD5, 8'h0A, 8'h0B, 8'h15};
    send_burst(b, 2);
    send_burst(b2, 2);
    check_results('{}, '{2'd3, 2'd3}, "ovf held");
    chk("ovf out_valid", out_valid, 1);
    chk("ovf head", out_data, 8'h01);
    e = {};
    for (int k = 1; k <= 16; k++) e.push_back({2'b00, 8'(k)});
    e.push_back(10'h300);
    rdy_mode = 1;
    check_results(e, '{}, "ovf drain");

    // Back-to-back good frames, 1-cycle gap, random consumer
    rdy_mode = 2;
    b  = '{8'h55, 8'h55, 8'hD5};
    b2 = '{8'h55, 8'hD5};
    for (int k = 0; k < 5; k++) b.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) b2.push_back(8'($urandom));
    b.push_back(8'h00);
    b2.push_back(8'h00);
    ref_frame(b, code, e);
    b[b.size() - 1] = 8'h00;
    for (int k = 3; k < b.size() - 1; k++) b[b.size() - 1] = b[b.size() - 1] + b[k];
    for (int k = 2; k < b2.size() - 1; k++) b2[b2.size() - 1] = b2[b2.size() - 1] + b2[k];
    ref_frame(b, code, e);
    ref_frame(b2, code2, e2);
    send_burst(b, 1);
    send_burst(b2, 2);
    foreach (e2[k]) e.push_back(e2[k]);
    check_results(e, '{code, code2}, "b2b");
    chk("b2b codes good", {code, code2}, 4'b0000);

    // Reset in the middle of a payload, then a good frame
    rdy_mode = 1;
    b = '{8'h55, 8'hD5, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (b[i]) begin
      step();
      rxd = b[i];
      rx_dv = 1'b1;
    end
    step();
    rst_n = 1'b0;
    rxd = 8'h55;
    step();
    q_base = got_q.size();
    c_base = got_codes.size();
    fc_m = 0;
    ec_m = 0;
    rst_n = 1'b1;
    rxd = 8'h66;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst frame_cnt", frame_cnt, 0);
    chk("mid-rst err_cnt", err_cnt, 0);
    step();
    rxd = 8'h77;
    step();
    rx_dv = 1'b0;
    rxd = 8'h00;
    step();
    step();
    b = '{8'h55, 8'h55, 8'hD5, 8'hA0, 8'h0B, 8'hAB};
    ref_frame(b, code, e);
    send_burst(b, 2);
    check_results(e, '{code}, "post-rst");

    // Randomized frames against the parsing model
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int kind, plen, n, pos;
      logic [7:0] s;
      kind = $urandom_range(0, 3);
      plen = $urandom_range(1, 4);
      n    = $urandom_range(1, 14);
      b = {};
      for (int k = 0; k < plen; k++) b.push_back(8'h55);
      b.push_back(8'hD5);
      s = 8'h00;
      for (int k = 0; k < n; k++) begin
        b.push_back(8'($urandom));
        s = s + b[b.size() - 1];
      end
      b.push_back(s);
      if (kind == 2) b[b.size() - 1] = s + 8'd1;
      if (kind == 3) begin
        pos = $urandom_range(0, plen);
        b[pos] = 8'($urandom);
      end
      ref_frame(b, code, e);
      send_burst(b, $urandom_range(1, 3));
      check_results(e, '{code}, $sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
